fifo_fwft_status: RTL and testbench

Parametrised synchronous circular FIFO with first-word-fall-through reads, full-depth use of storage, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. Next-generation buffer for NPU datapath stages, e.g. between the feature-map loader and the PE array and between PE output and the writeback engine. Producers and consumers back-pressure on the status flags.

---
 rtl/fifo_fwft_status.sv | 122 ++++++++++++
 tb/tb_fifo_fwft_status.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_status.sv
// Synchronous circular FIFO with first-word-fall-through head, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_fwft_status #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic rd_acc;
   logic wr_acc;
   logic mem_we;

   // Every status output is a decode of registered state only.
   assign count        = count_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign rd_acc = rd && !empty;
   // A full FIFO still takes a write when the same cycle frees a slot.
   assign wr_acc = wr && (!full || rd_acc);

   assign data_out = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end

         unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase

         if (wr && !wr_acc) begin
            overflow_d = 1'b1;
         end
         if (rd && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; data_out masks it to zero while empty, so stale words are never observable.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_fifo_fwft_status.sv
// Randomised and directed bench for fifo_fwft_status against a queue-based reference model.
module tb_fifo_fwft_status;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow, underflow;

   int total = 0;
   int bad   = 0;

   // Reference model: the FIFO contents as a plain queue plus the two sticky flags.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] rd_exp_q[$];
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   bit            mon_en = 1'b0;

   fifo_fwft_status #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
      .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst(rst_n), .flush(flush), .wr(wr), .rd(rd),
      .data_in(data_in), .data_out(data_out),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, record the expected pop, then advance the model at the edge.
   task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit f = 1'b0, input bit rs = 1'b1);
      int  n;
      bit  racc, wacc;
      wr = w; rd = r; data_in = d; flush = f; rst_n = rs;
      n = mq.size();
      if (rs && !f && r && n != 0) rd_exp_q.push_back(mq[0]);
      @(posedge clk);
      if (!rs || f) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         racc = r && (n > 0);
         wacc = w && ((n < DEPTH) || racc);
         if (w && !wacc) m_ovf = 1'b1;
         if (r && n == 0) m_udf = 1'b1;
         if (racc) void'(mq.pop_front());
         if (wacc) mq.push_back(d);
      end
      #1;
   endtask

   // Monitor: status against the model every cycle; data against the scoreboard on each DUT pop.
   always @(negedge clk) begin
      int            n;
      logic [DW-1:0] e;
      if (mon_en) begin
         n = mq.size();
         check("count",        32'(count),        32'(n));
         check("full",         32'(full),         32'(n == DEPTH));
         check("empty",        32'(empty),        32'(n == 0));
         check("almost_full",  32'(almost_full),  32'(n >= AF));
         check("almost_empty", 32'(almost_empty), 32'(n <= AE));
         check("overflow",     32'(overflow),     32'(m_ovf));
         check("underflow",    32'(underflow),    32'(m_udf));
         check("data_out",     data_out,          (n == 0) ? '0 : mq[0]);
         if (rst_n && !flush && rd && !empty) begin
            total++;
            if (rd_exp_q.size() == 0) begin
               bad++;
               $display("FAIL rd_pop at %0t: DUT popped %0h but no read was expected", $time, data_out);
            end else begin
               e = rd_exp_q.pop_front();
               if (data_out !== e) begin
                  bad++;
                  $display("FAIL rd_data at %0t: got %0h expected %0h", $time, data_out, e);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int wp, rp;
      // Reset then fill
      step(0, 0, '0, 0, 0);
      mon_en = 1'b1;
      step(0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 32'h10 + 32'(i));
      step(0, 0, '0);
      // Drain
      for (int i = 0; i < 8; i++) step(0, 1, '0);
      step(0, 0, '0);
      // Overflow then underflow, both sticky until flush
      for (int i = 0; i < 8; i++) step(1, 0, 32'h20 + 32'(i));
      step(1, 0, 32'hAA);
      for (int i = 0; i < 8; i++) step(0, 1, '0);
      step(0, 1, '0);
      step(0, 0, '0);
      step(0, 0, '0, 1);
      step(0, 0, '0);
      // Simultaneous read/write on full, then on empty
      for (int i = 0; i < 8; i++) step(1, 0, 32'h30 + 32'(i));
      step(1, 1, 32'h55);
      for (int i = 0; i < 8; i++) step(0, 1, '0);
      step(1, 1, 32'h66);
      step(0, 1, '0);
      step(0, 0, '0, 1);
      // Wrap-around
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 5; i++) step(1, 0, 32'(k * 5 + i));
         for (int i = 0; i < 5; i++) step(0, 1, '0);
      end
      step(0, 0, '0);
      // Flush mid-operation with a concurrent write, then the same with reset
      for (int i = 0; i < 3; i++) step(1, 0, 32'h40 + 32'(i));
      step(1, 1, 32'h77, 1);
      step(0, 0, '0);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h50 + 32'(i));
      step(0, 1, '0);
      step(1, 1, 32'h88, 0, 0);
      step(0, 0, '0);
      // Random phases with varying bias so full and empty are both exercised
      for (int p = 0; p < 16; p++) begin
         wp = $urandom_range(90, 10);
         rp = $urandom_range(90, 10);
         for (int i = 0; i < 100; i++) begin
            step($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom,
                 $urandom_range(63) == 0, $urandom_range(127) != 0);
         end
      end
      step(0, 0, '0);
      @(negedge clk);
      #1;
      check("rd_exp_left", 32'(rd_exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
